latch_bank_ctrl: RTL and testbench
==================================

Name: latch_bank_ctrl

Overview:
Write sequencer and round-robin arbiter for a bank of NLAT level-sensitive D latches (each d/en/q with its own reset).
- Accepts write requests from NREQ requesters and grants one at a time.
- Drives the shared latch data bus and generates a glitch-free, one-hot enable window framed by setup and hold cycles, so latch data never changes while any en is high.
- Sits between register-file clients and the latch array.

Parameters:
NREQ, 2, number of requesters (≥2)
DW, 8, latch data width
NLAT, 4, number of latches in the bank
AW, 2, address width, clog2(NLAT)
EN_CYCLES, 1, enable pulse length in clk cycles (≥1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester write request, level; held until ack
req_addr  input  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_data  input  NREQ*DW  packed write data, requester i at [i*DW +: DW]
ack  output  NREQ  one-cycle completion pulse to the granted requester
err  output  1  one-cycle pulse with ack when the captured addr ≥ NLAT
d_out  output  DW  shared data bus to all latch d inputs
en_out  output  NLAT  latch enables, at most one bit high
busy  output  1  high whenever state ≠ IDLE

Behaviour:
Reset (reset=0, async):
- state=IDLE; en_out=0, d_out=0, ack=0, err=0, busy=0; rr pointer=0.
- en_out must clear without waiting for clk, so no latch opens during reset.

FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE: if any req, grant by round-robin from the pointer. Capture winner index, addr and data into registers, then go to SETUP. With no req, stay in IDLE.
- SETUP (1 cycle): d_out = captured data; en_out = 0.
- PULSE (EN_CYCLES cycles, down-counter): en_out = one-hot(captured addr); d_out unchanged. If addr ≥ NLAT, en_out stays 0.
- HOLD (1 cycle): en_out = 0; d_out held; ack[winner] = 1; err = (addr ≥ NLAT). Rr pointer = winner+1 mod NREQ. Next state is IDLE.

Outputs and timing:
- All outputs are registered, so en_out never glitches.
- d_out keeps its last value in IDLE.
- Latency from req sampled in IDLE at edge t: SETUP at t+1, PULSE at t+2 … t+1+EN_CYCLES, ack at t+2+EN_CYCLES.
- Minimum write period is EN_CYCLES+3 cycles.

Boundary conditions:
- Simultaneous requests: the lowest index at or after the pointer wins; the others wait (no starvation, bounded by NREQ transactions).
- req, addr or data changing after the grant are ignored, because the values were captured.
- req deasserted before the grant: the requester is never granted.
- req dropped mid-transaction: the write still completes and ack still pulses.
- Requester holding req in the ack cycle: it is re-arbitrated as a new request in the following IDLE. The protocol requires requesters to drop req in the cycle after ack.
- Reset asserted mid-PULSE: en_out drops immediately, the transaction is aborted with no ack, and the pointer returns to 0.
- Counter width is clog2(EN_CYCLES)+1. The pointer wraps modulo NREQ.

Decomposition:
- Package latch_ctrl_pkg holds:
  - state encoding constants (IDLE=2'd0, SETUP=2'd1, PULSE=2'd2, HOLD=2'd3);
  - a localparam for the counter width.
- Sub-module rr_arbiter(NREQ): inputs req and ptr, outputs one-hot gnt and the encoded index. Purely combinational, instantiated once.
- FSM, capture registers and output registers live in latch_bank_ctrl.

Test Plan:
- Reset release: reset=0 for 2 cycles, then 1 with no req → en_out=0, d_out=0, ack=0 and busy=0 for 10 cycles.
- Single write: req[0]=1, addr0=2, data0=8'hA5 → SETUP d_out=A5/en_out=0; next cycle en_out=4'b0100; then en_out=0 with ack[0]=1; the attached latch2 q=A5 afterwards and the other latches are unchanged.
- Contention: req=2'b11 (addr 1/3, data 11/33) held until each ack → req0 is served first (en_out=0010), then req1 (en_out=1000); ack[0] precedes ack[1] by 4 cycles. Repeating the test shows requester 1 winning first.
- Stability check: for every cycle with en_out≠0, d_out equals its value in the previous cycle; en_out is never multi-hot (assertion over 200 random requests).
- Out-of-range: NLAT=3, addr=3 → en_out stays 0 throughout, and ack and err pulse together.
- Reset mid-PULSE: EN_CYCLES=3, assert reset at the 2nd PULSE cycle → en_out=0 asynchronously before the next clk edge, no ack, busy=0. After release, a new req0 write completes normally.

Source files
------------

// File: rtl/latch_ctrl_pkg.sv
// Shared types and sizing helpers for the latch bank write sequencer.
// Imported by the arbiter and the sequencer.
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int EN_CYCLES_DEF = 1;
  localparam int CNT_W = cnt_w(EN_CYCLES_DEF);

endpackage

// File: rtl/latch_bank_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
// Returns a one-hot grant and its encoded index.
module rr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);

  logic          found;
  logic [PW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = j;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write sequencer for a bank of level-sensitive latches: setup,
// one-hot enable window, hold, then ack to the granted requester.
module latch_bank_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DW        = 8,
  parameter int NLAT      = 4,
  parameter int AW        = 2,
  parameter int EN_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic [DW-1:0]      d_out,
  output logic [NLAT-1:0]    en_out,
  output logic               busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = cnt_w(EN_CYCLES);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   gidx;
  logic [NREQ-1:0] gnt;
  logic [AW-1:0]   cap_addr;
  logic [NLAT-1:0] sel;
  logic            oor;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx)
  );

  // Out-of-range addresses decode to no enable at all.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NLAT; i++)
      sel[i] = (cap_addr == AW'(i));
    oor = 32'(cap_addr) >= 32'(NLAT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      win      <= '0;
      cap_addr <= '0;
      d_out    <= '0;
      en_out   <= '0;
      ack      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            win      <= gidx;
            cap_addr <= req_addr[gidx*AW +: AW];
            d_out    <= req_data[gidx*DW +: DW];
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          en_out <= sel;
          cnt    <= CW'(EN_CYCLES - 1);
          state  <= PULSE;
        end
        PULSE: begin
          if (cnt == '0) begin
            en_out <= '0;
            ack    <= NREQ'(1) << win;
            err    <= oor;
            ptr    <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          ack   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Bench: two configurations (4 latches/1-cycle pulse and 3 latches/
// 3-cycle pulse) checked every cycle against a transaction-timeline model.
module tb_latch_bank_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [1:0]  req_a, req_b;
  logic [3:0]  ra_a, ra_b;
  logic [15:0] rd_a, rd_b;
  logic [1:0]  ack_a, ack_b;
  logic        err_a, err_b;
  logic [7:0]  d_a, d_b;
  logic [3:0]  en_a;
  logic [2:0]  en_b;
  logic        busy_a, busy_b;

  latch_bank_ctrl #(.NREQ(2), .DW(8), .NLAT(4), .AW(2), .EN_CYCLES(1)) dut_a (
    .clk(clk), .reset(rst_a), .req(req_a), .req_addr(ra_a),
    .req_data(rd_a), .ack(ack_a), .err(err_a), .d_out(d_a),
    .en_out(en_a), .busy(busy_a)
  );

  latch_bank_ctrl #(.NREQ(2), .DW(8), .NLAT(3), .AW(2), .EN_CYCLES(3)) dut_b (
    .clk(clk), .reset(rst_b), .req(req_b), .req_addr(ra_b),
    .req_data(rd_b), .ack(ack_b), .err(err_b), .d_out(d_b),
    .en_out(en_b), .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: t counts edges since the grant; the write's life is
  // setup (t=1), pulse (t=2..ec+1), ack (t=ec+2), then back to idle.
  typedef struct packed {
    bit         act;
    int         t;
    int         win;
    int         addr;
    int         ptr;
    logic [7:0] dout;
    logic [3:0] en;
    logic [1:0] ack;
    logic       err;
    logic       busy;
  } mdl_t;

  function automatic mdl_t mstep(input mdl_t m, input logic [1:0] rq,
                                 input logic [3:0] ra, input logic [15:0] rd,
                                 input int nlat, input int ec);
    int j;
    m.ack = '0;
    m.err = 1'b0;
    m.en  = '0;
    if (!m.act) begin
      m.busy = 1'b0;
      for (int k = 0; k < 2; k++) begin
        j = (m.ptr + k) % 2;
        if (!m.act && rq[j]) begin
          m.act  = 1'b1;
          m.t    = 1;
          m.win  = j;
          m.addr = int'(ra[j*2 +: 2]);
          m.dout = rd[j*8 +: 8];
          m.busy = 1'b1;
        end
      end
    end else begin
      m.t++;
      if (m.t <= ec + 1) begin
        m.en = (m.addr < nlat) ? 4'(1 << m.addr) : 4'd0;
      end else if (m.t == ec + 2) begin
        m.ack[m.win] = 1'b1;
        m.err = (m.addr >= nlat);
        m.ptr = (m.win + 1) % 2;
      end else begin
        m.act  = 1'b0;
        m.busy = 1'b0;
      end
    end
    return m;
  endfunction

  mdl_t ma = '0;
  mdl_t mb = '0;

  always @(posedge clk or negedge rst_a)
    if (!rst_a) ma = '0;
    else ma = mstep(ma, req_a, ra_a, rd_a, 4, 1);

  always @(posedge clk or negedge rst_b)
    if (!rst_b) mb = '0;
    else mb = mstep(mb, req_b, ra_b, rd_b, 3, 3);

  logic [7:0] pd_a = '0;
  logic [7:0] pd_b = '0;

  always @(negedge clk) begin
    if (rst_a) begin
      chk("a_en", en_a, ma.en);
      chk("a_dout", d_a, ma.dout);
      chk("a_ack", ack_a, ma.ack);
      chk("a_err", err_a, ma.err);
      chk("a_busy", busy_a, ma.busy);
      chk("a_onehot", $onehot0(en_a), 1);
      if (en_a != 0) chk("a_stable", d_a, pd_a);
    end
    if (rst_b) begin
      chk("b_en", {1'b0, en_b}, mb.en);
      chk("b_dout", d_b, mb.dout);
      chk("b_ack", ack_b, mb.ack);
      chk("b_err", err_b, mb.err);
      chk("b_busy", busy_b, mb.busy);
      chk("b_onehot", $onehot0(en_b), 1);
      if (en_b != 0) chk("b_stable", d_b, pd_b);
    end
    pd_a = d_a;
    pd_b = d_b;
  end

  // Latches hanging off bank A.
  logic [7:0] lq [4];
  always @(en_a or d_a or rst_a)
    for (int i = 0; i < 4; i++)
      if (!rst_a) lq[i] = '0;
      else if (en_a[i]) lq[i] = d_a;

  task automatic cont(input bit r1_first);
    int t0, t1, nen;
    logic [3:0] e1, e2;
    t0 = -1; t1 = -1; nen = 0; e1 = '0; e2 = '0;
    req_a = 2'b11;
    ra_a  = {2'd3, 2'd1};
    rd_a  = {8'h33, 8'h11};
    for (int n = 0; n < 30 && req_a != 0; n++) begin
      @(negedge clk);
      if (en_a != 0) begin
        if (nen == 0) e1 = en_a;
        else if (en_a != e1) e2 = en_a;
        nen++;
      end
      if (ack_a[0]) begin t0 = n; req_a[0] = 1'b0; end
      if (ack_a[1]) begin t1 = n; req_a[1] = 1'b0; end
    end
    chk("cont_done", req_a, 0);
    if (!r1_first) begin
      chk("cont_en1", e1, 4'b0010);
      chk("cont_en2", e2, 4'b1000);
      chk("cont_gap", t1 - t0, 4);
    end else begin
      chk("cont_en1", e1, 4'b1000);
      chk("cont_en2", e2, 4'b0010);
      chk("cont_gap", t0 - t1, 4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq, nack;
    bit seen;
    rst_a = 1'b0; rst_b = 1'b0;
    req_a = '0; req_b = '0;
    ra_a = '0; ra_b = '0; rd_a = '0; rd_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_en", en_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_dout", d_a, 0);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("rel_en", en_a, 0);
      chk("rel_dout", d_a, 0);
      chk("rel_ack", ack_a, 0);
      chk("rel_busy", busy_a, 0);
    end

    cont(1'b0);

    @(negedge clk);
    req_a = 2'b01; ra_a = 4'd2; rd_a = 16'h00A5;
    @(negedge clk);
    chk("sw_setup_d", d_a, 8'hA5);
    chk("sw_setup_en", en_a, 0);
    chk("sw_setup_busy", busy_a, 1);
    @(negedge clk);
    chk("sw_pulse_en", en_a, 4'b0100);
    @(negedge clk);
    chk("sw_hold_en", en_a, 0);
    chk("sw_hold_ack", ack_a, 2'b01);
    req_a = '0;
    @(negedge clk);
    chk("sw_idle_ack", ack_a, 0);
    chk("sw_idle_busy", busy_a, 0);
    chk("sw_q0", lq[0], 8'h00);
    chk("sw_q1", lq[1], 8'h11);
    chk("sw_q2", lq[2], 8'hA5);
    chk("sw_q3", lq[3], 8'h33);

    cont(1'b1);

    nreq = 0;
    for (int n = 0; n < 5000 && (nreq < 200 || req_a != 0); n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (ack_a[i]) begin
          req_a[i] = 1'b0;
        end else if (!req_a[i] && nreq < 200 && $urandom_range(0, 2) == 0) begin
          req_a[i] = 1'b1;
          ra_a[i*2 +: 2] = 2'($urandom);
          rd_a[i*8 +: 8] = 8'($urandom);
          nreq++;
        end else if (req_a[i] && $urandom_range(0, 3) == 0) begin
          rd_a[i*8 +: 8] = 8'($urandom);
          ra_a[i*2 +: 2] = 2'($urandom);
        end else if (req_a[i] && $urandom_range(0, 15) == 0) begin
          req_a[i] = 1'b0;
        end
      end
    end
    chk("rand_done", req_a, 0);

    @(negedge clk);
    req_b = 2'b01; ra_b = 4'd3; rd_b = 16'h0077;
    nack = 0;
    for (int n = 1; n <= 10 && nack == 0; n++) begin
      @(negedge clk);
      chk("oor_en", en_b, 0);
      if (ack_b[0]) begin
        nack = n;
        chk("oor_err", err_b, 1);
        req_b = '0;
      end
    end
    chk("oor_lat", nack, 5);

    @(negedge clk);
    req_b = 2'b01; ra_b = 4'd1; rd_b = 16'h00C3;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (en_b != 0) seen = 1'b1;
    end
    chk("mid_en1", en_b, 3'b010);
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_en_async", en_b, 0);
    chk("mid_busy", busy_b, 0);
    chk("mid_ack", ack_b, 0);
    req_b = '0;
    repeat (4) begin
      @(negedge clk);
      chk("mid_noack", ack_b, 0);
    end
    rst_b = 1'b1;
    @(negedge clk);
    req_b = 2'b01; ra_b = 4'd2; rd_b = 16'h005A;
    seen = 1'b0; nack = 0;
    for (int n = 1; n <= 10 && nack == 0; n++) begin
      @(negedge clk);
      if (en_b == 3'b100) seen = 1'b1;
      if (ack_b[0]) begin
        nack = n;
        chk("post_d", d_b, 8'h5A);
        chk("post_err", err_b, 0);
        req_b = '0;
      end
    end
    chk("post_en_seen", seen, 1);
    chk("post_lat", nack, 5);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
